// File: rtl/dmem_sram_bridge_pkg.sv
// Shared types for the memory-stage data port and its SRAM-like bus bridge.
// Holds request layouts, size encoding and bridge FSM states.
package dmem_sram_bridge_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;

    typedef enum logic [SIZE_W-1:0] {
        MSIZE_B = 2'd0,
        MSIZE_H = 2'd1,
        MSIZE_W = 2'd2
    } msize_t;

    typedef struct packed {
        logic              ren;
        logic [ADDR_W-1:0] addr;
        msize_t            size;
    } m_r_t;

    typedef struct packed {
        logic              wen;
        logic [ADDR_W-1:0] addr;
        msize_t            size;
        logic [DATA_W-1:0] wd;
    } m_w_t;

    typedef enum logic [1:0] {
        DB_IDLE = 2'd0,
        DB_REQ  = 2'd1,
        DB_WAIT = 2'd2,
        DB_DONE = 2'd3
    } dbridge_state_t;

endpackage

// File: rtl/dmem_sram_bridge_if.sv
// Memory-stage request/response signals plus the SRAM-like data bus.
// dbridge is the bridge view, master the memory stage, slave the SRAM side.
interface dmem_sram_bridge_if;
    import dmem_sram_bridge_pkg::*;

    m_r_t              mread;
    m_w_t              mwrite;
    logic [DATA_W-1:0] rd;

    logic              data_req;
    logic              data_wr;
    logic [SIZE_W-1:0] data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport dbridge (
        input  mread, mwrite, data_addr_ok, data_data_ok, data_rdata,
        output rd, data_req, data_wr, data_size, data_addr, data_wdata
    );

    modport master (
        output mread, mwrite,
        input  rd
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );

endinterface

// File: rtl/dmem_sram_bridge_addr_map.sv
// Virtual-to-physical map: kseg0/kseg1 drop addr[31:29] when PHYS_MAP is set.
module dmem_sram_bridge_addr_map
    import dmem_sram_bridge_pkg::*;
#(
    parameter bit PHYS_MAP = 1'b1
) (
    input  logic [ADDR_W-1:0] vaddr,
    output logic [ADDR_W-1:0] paddr_c
);

    always_comb begin
        paddr_c = vaddr;
        if (PHYS_MAP && (vaddr[31:30] == 2'b10)) begin
            paddr_c = {3'b000, vaddr[28:0]};
        end
    end

endmodule

// File: rtl/dmem_sram_bridge.sv
// Memory-stage data port responder: one request at a time onto the SRAM-like bus,
// returning the raw read word and stalling the pipeline while it is outstanding.
module dmem_sram_bridge
    import dmem_sram_bridge_pkg::*;
#(
    parameter bit PHYS_MAP = 1'b1
) (
    input  logic                clk,
    input  logic                resetn,
    dmem_sram_bridge_if.dbridge bus,
    input  logic                advance,
    input  logic                flush,
    output logic                dstall
);

    dbridge_state_t    state_q;
    logic              drop_q;
    logic              req_q;
    logic              wr_q;
    msize_t            size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_q;

    logic              wen_c;
    logic              req_valid_c;
    logic              drop_now_c;
    msize_t            size_c;
    logic [ADDR_W-1:0] vaddr_c;
    logic [ADDR_W-1:0] paddr_c;

    // Write wins when both strobes are set (illegal, checked below).
    assign wen_c       = bus.mwrite.wen;
    assign req_valid_c = bus.mread.ren | wen_c;
    assign vaddr_c     = wen_c ? bus.mwrite.addr : bus.mread.addr;
    assign size_c      = wen_c ? bus.mwrite.size : bus.mread.size;
    assign drop_now_c  = drop_q | flush;

    dmem_sram_bridge_addr_map #(
        .PHYS_MAP (PHYS_MAP)
    ) u_addr_map (
        .vaddr   (vaddr_c),
        .paddr_c (paddr_c)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DB_IDLE;
            drop_q  <= 1'b0;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= MSIZE_B;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else begin
            unique case (state_q)
                DB_IDLE: begin
                    if (req_valid_c && !flush) begin
                        wr_q    <= wen_c;
                        size_q  <= size_c;
                        addr_q  <= paddr_c;
                        wdata_q <= bus.mwrite.wd;
                        req_q   <= 1'b1;
                        drop_q  <= 1'b0;
                        state_q <= DB_REQ;
                    end
                end
                DB_REQ: begin
                    if (flush) begin
                        drop_q <= 1'b1;
                    end
                    if (bus.data_addr_ok) begin
                        req_q   <= 1'b0;
                        state_q <= DB_WAIT;
                    end
                end
                DB_WAIT: begin
                    if (flush) begin
                        drop_q <= 1'b1;
                    end
                    // A flushed transaction still drains on the bus; its data is discarded.
                    if (bus.data_data_ok) begin
                        if (!wr_q && !drop_now_c) begin
                            rd_q <= bus.data_rdata;
                        end
                        drop_q  <= 1'b0;
                        state_q <= drop_now_c ? DB_IDLE : DB_DONE;
                    end
                end
                DB_DONE: begin
                    if (flush || advance) begin
                        state_q <= DB_IDLE;
                    end
                end
                default: state_q <= DB_IDLE;
            endcase
        end
    end

    // Stall rises in the launch cycle itself so the pipeline freezes before REQ.
    always_comb begin
        dstall = 1'b0;
        if (resetn) begin
            unique case (state_q)
                DB_IDLE: dstall = req_valid_c & ~flush;
                DB_REQ:  dstall = 1'b1;
                DB_WAIT: dstall = 1'b1;
                DB_DONE: dstall = 1'b0;
                default: dstall = 1'b0;
            endcase
        end
    end

    assign bus.data_req   = req_q;
    assign bus.data_wr    = wr_q;
    assign bus.data_size  = SIZE_W'(size_q);
    assign bus.data_addr  = addr_q;
    assign bus.data_wdata = wdata_q;
    assign bus.rd         = rd_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (resetn && state_q == DB_IDLE) begin
            assert (!(bus.mread.ren && bus.mwrite.wen));
        end
        if (resetn && state_q == DB_REQ) begin
            assert (!bus.data_data_ok);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Self-checking bench for dmem_sram_bridge: directed scenarios plus randomized
// transactions against a transaction-level expectation of stall length, bus fields and rd.
module tb_dmem_sram_bridge;
    import dmem_sram_bridge_pkg::*;

    logic clk;
    logic resetn;
    logic advance;
    logic flush;
    logic dstall;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rd = 32'h0;

    dmem_sram_bridge_if bus ();

    dmem_sram_bridge #(
        .PHYS_MAP (1'b1)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .bus     (bus),
        .advance (advance),
        .flush   (flush),
        .dstall  (dstall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Physical address by segment ranges.
    function automatic logic [31:0] exp_phys(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a < 32'hA000_0000) return a - 32'h8000_0000;
        if (a >= 32'hA000_0000 && a < 32'hC000_0000) return a - 32'hA000_0000;
        return a;
    endfunction

    task automatic set_req(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] wd);
        bus.mread.ren   = !wr;
        bus.mread.addr  = wr ? $urandom : a;
        bus.mread.size  = msize_t'(wr ? 2'd1 : sz);
        bus.mwrite.wen  = wr;
        bus.mwrite.addr = wr ? a : $urandom;
        bus.mwrite.size = msize_t'(wr ? sz : 2'd0);
        bus.mwrite.wd   = wd;
    endtask

    task automatic clear_req();
        bus.mread.ren  = 1'b0;
        bus.mwrite.wen = 1'b0;
    endtask

    // One full transaction: IDLE launch, REQ for aok_dly+1 cycles, WAIT for dok_dly+1,
    // DONE for hold+1 cycles, then a quiet cycle.
    task automatic drive_txn(input string nm, input bit wr, input logic [31:0] a,
                             input logic [1:0] sz, input logic [31:0] wd, input int aok_dly,
                             input int dok_dly, input logic [31:0] rdat, input int hold,
                             input bit end_flush);
        int stalls;
        int reqs;
        logic [31:0] pa;
        pa = exp_phys(a);
        stalls = 0;
        reqs = 0;
        @(posedge clk); #1;
        set_req(wr, a, sz, wd);
        advance = 1'b0;
        flush = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        @(negedge clk);
        if (dstall) stalls++;
        checks++;
        if (bus.rd !== exp_rd) begin
            errors++;
            $display("FAIL %s idle_rd: got %h expected %h", nm, bus.rd, exp_rd);
        end
        checks++;
        if (bus.data_req !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_req: got %b expected 0", nm, bus.data_req);
        end
        for (int i = 0; i <= aok_dly; i++) begin
            @(posedge clk); #1;
            bus.data_addr_ok = (i == aok_dly);
            @(negedge clk);
            if (dstall) stalls++;
            if (bus.data_req) reqs++;
            checks++;
            if ({bus.data_wr, bus.data_size, bus.data_addr} !== {wr, sz, pa}) begin
                errors++;
                $display("FAIL %s req_fields: got wr=%b size=%0d addr=%h expected wr=%b size=%0d addr=%h",
                         nm, bus.data_wr, bus.data_size, bus.data_addr, wr, sz, pa);
            end
            if (wr) begin
                checks++;
                if (bus.data_wdata !== wd) begin
                    errors++;
                    $display("FAIL %s req_wdata: got %h expected %h", nm, bus.data_wdata, wd);
                end
            end
        end
        for (int i = 0; i <= dok_dly; i++) begin
            @(posedge clk); #1;
            bus.data_addr_ok = 1'b0;
            bus.data_data_ok = (i == dok_dly);
            bus.data_rdata = (i == dok_dly) ? rdat : $urandom;
            @(negedge clk);
            if (dstall) stalls++;
            if (bus.data_req) reqs++;
        end
        if (!wr) exp_rd = rdat;
        for (int i = 0; i <= hold; i++) begin
            @(posedge clk); #1;
            bus.data_data_ok = 1'b0;
            bus.data_rdata = $urandom;
            advance = (i == hold) && !end_flush;
            flush = (i == hold) && end_flush;
            @(negedge clk);
            if (dstall) stalls++;
            if (bus.data_req) reqs++;
            checks++;
            if (bus.rd !== exp_rd) begin
                errors++;
                $display("FAIL %s done_rd: got %h expected %h", nm, bus.rd, exp_rd);
            end
        end
        checks++;
        if (stalls != aok_dly + dok_dly + 3) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", nm, stalls, aok_dly + dok_dly + 3);
        end
        checks++;
        if (reqs != aok_dly + 1) begin
            errors++;
            $display("FAIL %s req_cycles: got %0d expected %0d", nm, reqs, aok_dly + 1);
        end
        @(posedge clk); #1;
        clear_req();
        advance = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if ({dstall, bus.data_req} !== 2'b00) begin
            errors++;
            $display("FAIL %s after_idle: got stall=%b req=%b expected 0 0", nm, dstall, bus.data_req);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        advance = 1'b0;
        flush = 1'b0;
        clear_req();
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata = 32'h0;
        #12;
        checks++;
        if ({dstall, bus.data_req, bus.rd} !== 34'h0) begin
            errors++;
            $display("FAIL reset_state: got stall=%b req=%b rd=%h expected 0 0 0",
                     dstall, bus.data_req, bus.rd);
        end
        @(negedge clk);
        resetn = 1'b1;
        exp_rd = 32'h0;
    endtask

    task automatic test_read_word();
        drive_txn("read_word", 1'b0, 32'hBFC0_0100, 2'd2, 32'h0, 0, 0, 32'hDEAD_BEEF, 2, 1'b0);
    endtask

    task automatic test_byte_write();
        drive_txn("byte_write", 1'b1, 32'h8000_0003, 2'd0, 32'h5500_0000, 0, 1, 32'hFFFF_FFFF, 0, 1'b0);
    endtask

    task automatic test_addr_ok_stall();
        drive_txn("addr_ok_stall", 1'b0, 32'h8000_1234, 2'd1, 32'h0, 4, 0, 32'h0BAD_F00D, 0, 1'b0);
    endtask

    task automatic test_flush_wait();
        @(posedge clk); #1;
        set_req(1'b0, 32'h8000_0010, 2'd2, 32'h0);
        @(negedge clk);
        checks++;
        if (dstall !== 1'b1) begin
            errors++;
            $display("FAIL flush_wait launch_stall: got %b expected 1", dstall);
        end
        @(posedge clk); #1;
        bus.data_addr_ok = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.data_req !== 1'b1) begin
            errors++;
            $display("FAIL flush_wait req: got %b expected 1", bus.data_req);
        end
        @(posedge clk); #1;
        bus.data_addr_ok = 1'b0;
        flush = 1'b1;
        clear_req();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (dstall !== 1'b1) begin
                errors++;
                $display("FAIL flush_wait drain_stall[%0d]: got %b expected 1", i, dstall);
            end
            @(posedge clk); #1;
            flush = 1'b0;
            bus.data_data_ok = (i == 1);
            bus.data_rdata = (i == 1) ? 32'h1234_5678 : $urandom;
        end
        bus.data_data_ok = 1'b0;
        // Next transaction starts immediately: stalls only if the bridge is back in IDLE.
        drive_txn("after_flush", 1'b0, 32'hA000_0040, 2'd2, 32'h0, 1, 0, 32'h600D_CAFE, 0, 1'b0);
    endtask

    task automatic test_flush_idle();
        @(posedge clk); #1;
        set_req(1'b0, 32'h8000_0020, 2'd2, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (dstall !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle stall: got %b expected 0", dstall);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        clear_req();
        @(negedge clk);
        checks++;
        if ({dstall, bus.data_req} !== 2'b00) begin
            errors++;
            $display("FAIL flush_idle no_launch: got stall=%b req=%b expected 0 0", dstall, bus.data_req);
        end
    endtask

    task automatic test_back_to_back();
        drive_txn("done_hold", 1'b0, 32'h8000_0100, 2'd2, 32'h0, 0, 0, 32'h1111_2222, 3, 1'b0);
        drive_txn("next_read", 1'b0, 32'h8000_0104, 2'd2, 32'h0, 0, 0, 32'h3333_4444, 0, 1'b0);
        drive_txn("flush_done", 1'b0, 32'h0000_0200, 2'd2, 32'h0, 0, 2, 32'h5555_6666, 1, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] a;
        for (int n = 0; n < 24; n++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0: a = {3'b100, r[28:0]};
                1: a = {3'b101, r[28:0]};
                2: a = {1'b0, r[30:0]};
                default: a = {2'b11, r[29:0]};
            endcase
            drive_txn("random", 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 2)), $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                      int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        drive_txn("pre_reset", 1'b0, 32'h8000_0300, 2'd2, 32'h0, 0, 0, 32'hA5A5_5A5A, 0, 1'b0);
        @(posedge clk); #1;
        set_req(1'b0, 32'h8000_0304, 2'd2, 32'h0);
        @(posedge clk); #1;
        bus.data_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus.data_addr_ok = 1'b0;
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if ({dstall, bus.data_req, bus.rd} !== 34'h0) begin
            errors++;
            $display("FAIL reset_mid: got stall=%b req=%b rd=%h expected 0 0 0",
                     dstall, bus.data_req, bus.rd);
        end
        clear_req();
        @(negedge clk);
        resetn = 1'b1;
        exp_rd = 32'h0;
        drive_txn("post_reset", 1'b1, 32'hA000_0008, 2'd2, 32'hCAFE_0001, 0, 0, 32'h7777_7777, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_read_word();
        test_byte_write();
        test_addr_ok_stall();
        test_flush_wait();
        test_flush_idle();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_sram_bridge.md
Name: dmem_sram_bridge

Overview:
- Responder end of the memory-stage data port: consumes the `m_r_t` / `m_w_t` requests driven by the memory stage.
- Issues each request as one transaction on an SRAM-like data bus: req/addr_ok phase, then data_ok/rdata phase.
- Returns the raw read word `rd` toward writeback and raises `dstall` while a transaction is outstanding.
- Sits between the memory stage / writeback and the top-level data bus; the hazard unit ORs `dstall` into `stallM`, `stallE`, `stallD` and `stallF`.

Parameters:
- PHYS_MAP, 1, when 1, kseg0/kseg1 addresses (0x8000_0000–0xBFFF_FFFF) are mapped by clearing addr[31:29]; when 0, addresses pass unchanged.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- mread  in  m_r_t  fields: ren, addr[31:0], size[1:0] (0 = byte, 1 = half, 2 = word).
- mwrite  in  m_w_t  fields: wen, addr[31:0], size[1:0], wd[31:0]; wd is already lane-shifted by the memory stage.
- advance  in  1  memory stage moves to writeback this cycle (not stalled by any source).
- flush  in  1  exception flush of the memory stage.
- rd  out  32  read data: raw aligned word, not extended.
- dstall  out  1  data-side stall request.
- data_req  out  1  SRAM-like request.
- data_wr  out  1  1 = write.
- data_size  out  2  transfer size.
- data_addr  out  32  physical address.
- data_wdata  out  32  write data.
- data_addr_ok  in  1  address accepted.
- data_data_ok  in  1  transaction complete.
- data_rdata  in  32  returned read data.

Behaviour:
- Reset values:
  - state = IDLE; data_req = 0; dstall = 0; rd = 0.
  - Latched wr/size/addr/wdata = 0; drop flag = 0.
- Request valid = `mread.ren | mwrite.wen`. `wen` has priority if both are set; that case is illegal and asserted in simulation.
- Address: physical address = PHYS_MAP-mapped version of the selected addr.
- State IDLE:
  - Request valid and no flush: latch wr/size/addr/wd; dstall = 1 combinationally in this same cycle; next state REQ.
  - No request: dstall = 0.
- State REQ:
  - data_req = 1; data_wr/size/addr/wdata driven from the latches, held stable.
  - data_req is never withdrawn before data_addr_ok.
  - data_addr_ok → WAIT. dstall = 1.
- State WAIT:
  - data_req = 0; dstall = 1.
  - data_data_ok → latch data_rdata into rd (reads only; writes leave rd unchanged).
  - Next state DONE, or IDLE if the drop flag is set.
  - data_data_ok is accepted no earlier than the cycle after addr_ok. data_ok arriving in REQ is a protocol error (asserted).
- State DONE:
  - dstall = 0; rd holds the latched value.
  - advance → IDLE. Otherwise stay in DONE, so an unchanged request is never re-issued.
- Latency: read with addr_ok in the first REQ cycle and data_ok one cycle later → dstall high for 3 cycles (IDLE, REQ, WAIT); rd valid from the DONE cycle.
- Flush handling:
  - Flush in IDLE: no request is launched.
  - Flush in REQ or WAIT: set the drop flag. The transaction still completes on the bus (no cancel); its response is discarded; return to IDLE with dstall = 1 until data_ok.
  - Flush in DONE → IDLE.
- flush and advance in the same cycle: flush wins.
- Reset mid-transaction: immediate return to IDLE; the bus side is owned by the top-level reset.
- Only one outstanding transaction ever exists.

Decomposition:
- Shared package (mips.svh) holds:
  - `m_r_t` and `m_w_t` field layout.
  - `msize_t` encoding (MSIZE_B = 0, MSIZE_H = 1, MSIZE_W = 2).
  - `dbridge_state_t` enum (IDLE, REQ, WAIT, DONE).
- Sub-module: `addr_map` (combinational kseg0/kseg1 → physical, PHYS_MAP-controlled); reused by the instruction-side bridge.
- Interface: add modport `dbridge` to `memory_dram` (input mread, mwrite; output rd).
- Add `dstall` to `hazard_intf` as an input to the hazard unit.

Test Plan:
- Word read of 0xBFC0_0100; addr_ok on the first REQ cycle; data_ok one cycle later with 0xDEAD_BEEF → data_addr = 0x1FC0_0100, data_size = 2, dstall high for exactly 3 cycles, rd = 0xDEAD_BEEF in DONE until advance.
- Byte write to 0x8000_0003, wd = 0x5500_0000 → data_wr = 1, data_size = 0, data_addr = 0x0000_0003, data_wdata = 0x5500_0000; rd unchanged.
- addr_ok held low 4 cycles → data_req and all data_* stable for all 5 REQ cycles; dstall stays 1.
- flush in WAIT, data_ok 2 cycles later with 0x1234_5678 → rd keeps its old value, state returns to IDLE, no DONE cycle.
- DONE with advance = 0 for 3 cycles while the request stays asserted → no second data_req; advance = 1 → IDLE; a new read next cycle issues normally.
- resetn low during WAIT → state IDLE, dstall = 0, rd = 0 asynchronously.
